// File: rtl/branch_pkg.sv
// Shared types for the branch resolution stage: control-transfer kinds, branch condition
// codes, skid-buffer states and the registered redirect record.
package branch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    CfBranch = 2'd0,
    CfJal    = 2'd1,
    CfJalr   = 2'd2,
    CfNone   = 2'd3
  } cf_kind_e;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            mispredict;
    logic            illegal;
    logic            misalign;
  } br_result_t;

endpackage

// File: rtl/branch_skid_buf.sv
// Two-entry valid/ready skid buffer; head_q always holds the oldest record.
// in_ready_o depends only on registered state.
module branch_skid_buf
  import branch_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  skid_state_e      state_q, state_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             accept, emit;

  assign in_ready_o  = (state_q != StTwo);
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = head_q;
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && emit) begin
          head_d = in_data_i;
        end else if (accept) begin
          tail_d  = in_data_i;
          state_d = StTwo;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (emit) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops everything, including a same-cycle accept; a same-cycle emit is delivered.
    if (flush_i) state_d = StEmpty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: decides taken/target/link/mispredict and queues the record in a skid buffer.
// Define BRANCH_MISALIGN_TRAP_EN to flag taken targets that are not 4-byte aligned.
module branch_resolve
  import branch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_ltu,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misalign
);

  br_result_t      res, out_rec;
  cf_kind_e        kind;
  logic            cond, f3_illegal;
  logic [XLEN-1:0] pc_imm, jalr_sum;

  assign kind     = cf_kind_e'(in_kind);
  assign pc_imm   = in_pc + in_imm;
  assign jalr_sum = in_rs1 + in_imm;

  always_comb begin
    cond       = 1'b0;
    f3_illegal = 1'b0;
    unique case (in_funct3)
      BEQ:     cond = cmp_eq;
      BNE:     cond = ~cmp_eq;
      BLT:     cond = cmp_lt;
      BGE:     cond = ~cmp_lt;
      BLTU:    cond = cmp_ltu;
      BGEU:    cond = ~cmp_ltu;
      default: f3_illegal = 1'b1;
    endcase
  end

  always_comb begin
    res        = '0;
    res.link   = in_pc + XLEN'(4);
    res.target = pc_imm;
    unique case (kind)
      CfBranch: begin
        res.taken   = cond;
        res.illegal = f3_illegal;
      end
      CfJal:  res.taken = 1'b1;
      CfJalr: begin
        res.taken  = 1'b1;
        res.target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: res.taken = 1'b0;
    endcase
    // Illegal and NONE records are never taken, so this reduces to pred_taken for them.
    res.mispredict = (res.taken != pred_taken) | (res.taken & (res.target != pred_target));
`ifdef BRANCH_MISALIGN_TRAP_EN
    res.misalign = res.taken & (res.target[1:0] != 2'b00);
`else
    res.misalign = 1'b0;
`endif
  end

  branch_skid_buf #(
    .Width($bits(br_result_t))
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (res),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_rec)
  );

  assign out_taken      = out_rec.taken;
  assign out_target     = out_rec.target;
  assign out_link       = out_rec.link;
  assign out_mispredict = out_rec.mispredict;
  assign out_illegal    = out_rec.illegal;
  assign out_misalign   = out_rec.misalign;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve: resolution table, skid-buffer ordering, flush, reset.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1, pred_target;
  logic        cmp_eq, cmp_lt, cmp_ltu, pred_taken;
  logic        out_valid, out_taken, out_mispredict, out_illegal, out_misalign;
  logic [31:0] out_target, out_link;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_kind       (in_kind),
    .in_funct3     (in_funct3),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1        (in_rs1),
    .cmp_eq        (cmp_eq),
    .cmp_lt        (cmp_lt),
    .cmp_ltu       (cmp_ltu),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taken     (out_taken),
    .out_target    (out_target),
    .out_link      (out_link),
    .out_mispredict(out_mispredict),
    .out_illegal   (out_illegal),
    .out_misalign  (out_misalign)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, lt, ltu, pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_target, e_link;
    logic        e_mis, e_ill, e_mal;
  } vec_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_kind     = v.kind;
    in_funct3   = v.f3;
    in_pc       = v.pc;
    in_imm      = v.imm;
    in_rs1      = v.rs1;
    cmp_eq      = v.eq;
    cmp_lt      = v.lt;
    cmp_ltu     = v.ltu;
    pred_taken  = v.pt;
    pred_target = v.ptgt;
  endtask

  // JAL record whose target (pc + 0x10) identifies it in ordering tests.
  task automatic drive_tag(input logic [31:0] pc);
    vec_t v;
    v = '{2'd1, 3'd0, pc, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
          1'b1, pc + 32'h10, pc + 32'h4, 1'b1, 1'b0, 1'b0};
    drive(v);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'd0, 3'd4, 32'h100, 32'h20, 32'h0, 0, 1, 0, 0, 32'h0,
                 1, 32'h120, 32'h104, 1, 0, 0};
    vecs[1]  = '{2'd2, 3'd0, 32'h2000, 32'h4, 32'h1003, 0, 0, 0, 1, 32'h1006,
                 1, 32'h1006, 32'h2004, 0, 0, 1};
    vecs[2]  = '{2'd0, 3'd2, 32'h40, 32'h10, 32'h0, 0, 0, 0, 1, 32'h50,
                 0, 32'h50, 32'h44, 1, 1, 0};
    vecs[3]  = '{2'd1, 3'd7, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, 0, 0, 1, 32'h4,
                 1, 32'h4, 32'h0, 0, 0, 0};
    vecs[4]  = '{2'd0, 3'd0, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 0, 32'h0,
                 0, 32'h1F0, 32'h204, 0, 0, 0};
    vecs[5]  = '{2'd0, 3'd7, 32'h300, 32'h8, 32'h0, 0, 0, 1, 0, 32'h0,
                 0, 32'h308, 32'h304, 0, 0, 0};
    vecs[6]  = '{2'd0, 3'd5, 32'h400, 32'h40, 32'h0, 0, 0, 1, 1, 32'h444,
                 1, 32'h440, 32'h404, 1, 0, 0};
    vecs[7]  = '{2'd0, 3'd1, 32'h500, 32'hC, 32'h0, 0, 0, 0, 1, 32'h50C,
                 1, 32'h50C, 32'h504, 0, 0, 0};
    vecs[8]  = '{2'd3, 3'd0, 32'h600, 32'h0, 32'h0, 1, 0, 0, 1, 32'h600,
                 0, 32'h0, 32'h604, 1, 0, 0};
    vecs[9]  = '{2'd1, 3'd0, 32'h100, 32'h2, 32'h0, 0, 0, 0, 1, 32'h102,
                 1, 32'h102, 32'h104, 0, 0, 1};
    vecs[10] = '{2'd0, 3'd6, 32'h700, 32'h100, 32'h0, 0, 0, 1, 1, 32'h800,
                 1, 32'h800, 32'h704, 0, 0, 0};
    vecs[11] = '{2'd0, 3'd4, 32'h800, 32'h4, 32'h0, 0, 0, 1, 1, 32'h804,
                 0, 32'h804, 32'h804, 1, 0, 0};
    vecs[12] = '{2'd0, 3'd3, 32'h900, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0,
                 0, 32'h900, 32'h904, 0, 1, 0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_target", 64'(out_target), 64'd0);
    check("rst out_link", 64'(out_link), 64'd0);
    check("rst flags", 64'({out_taken, out_mispredict, out_illegal, out_misalign}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Resolution table, one record at a time.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      logic exp_mal;
`ifdef BRANCH_MISALIGN_TRAP_EN
      exp_mal = vecs[i].e_mal;
`else
      exp_mal = 1'b0;
`endif
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d taken", i), 64'(out_taken), 64'(vecs[i].e_taken));
      if (vecs[i].kind != 2'd3)
        check($sformatf("v%0d target", i), 64'(out_target), 64'(vecs[i].e_target));
      check($sformatf("v%0d link", i), 64'(out_link), 64'(vecs[i].e_link));
      check($sformatf("v%0d mispredict", i), 64'(out_mispredict), 64'(vecs[i].e_mis));
      check($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(vecs[i].e_ill));
      check($sformatf("v%0d misalign", i), 64'(out_misalign), 64'(exp_mal));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d drained", i), 64'(out_valid), 64'd0);
    end

    // Back-to-back accepts with downstream stalled, then ordered drain.
    out_ready = 1'b0;
    drive_tag(32'h1000);
    in_valid = 1'b1;
    @(negedge clk);
    check("fill1 in_ready", 64'(in_ready), 64'd1);
    check("fill1 target", 64'(out_target), 64'h1010);
    drive_tag(32'h2000);
    @(negedge clk);
    check("fill2 in_ready", 64'(in_ready), 64'd0);
    check("fill2 target", 64'(out_target), 64'h1010);
    drive_tag(32'h3000);
    @(negedge clk);
    check("stall in_ready", 64'(in_ready), 64'd0);
    check("stall target", 64'(out_target), 64'h1010);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain1 valid", 64'(out_valid), 64'd1);
    check("drain1 target", 64'(out_target), 64'h2010);
    check("drain1 in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("drain2 valid", 64'(out_valid), 64'd0);

    // Streaming at one record per cycle.
    for (int i = 0; i < 4; i++) begin
      drive_tag(32'h4000 + 32'(i) * 32'h100);
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("stream%0d target", i), 64'(out_target),
            64'(32'h4010 + 32'(i) * 32'h100));
      check($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream drained", 64'(out_valid), 64'd0);

    // Flush while full with a record offered.
    out_ready = 1'b0;
    drive_tag(32'h5000); in_valid = 1'b1; @(negedge clk);
    drive_tag(32'h6000); @(negedge clk);
    check("preflush in_ready", 64'(in_ready), 64'd0);
    drive_tag(32'h7000); flush = 1'b1; @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush2 out_valid", 64'(out_valid), 64'd0);
    check("flush2 in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("flush2 quiet", 64'(out_valid), 64'd0);

    // Flush with one buffered and a same-cycle accept: both discarded.
    out_ready = 1'b0;
    drive_tag(32'h8000); in_valid = 1'b1; @(negedge clk);
    drive_tag(32'h9000); flush = 1'b1; @(negedge clk);
    flush = 1'b0;
    check("flush1 out_valid", 64'(out_valid), 64'd0);
    drive_tag(32'hA000); @(negedge clk);
    in_valid = 1'b0;
    check("postflush target", 64'(out_target), 64'hA010);
    out_ready = 1'b1; @(negedge clk);
    check("postflush drained", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    drive_tag(32'hB000); in_valid = 1'b1; @(negedge clk);
    drive_tag(32'hC000); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst target", 64'(out_target), 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst quiet", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage sitting directly downstream of the signed/unsigned operand comparator in the execute path. Consumes the comparator's equal/less-than flags together with the decoded control-transfer fields, decides taken/not-taken, computes target and link addresses, checks them against the front-end prediction, and hands a registered redirect record to the PC/commit logic through a two-entry valid/ready skid buffer.

## Interface
- XLEN, 32, datapath and address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill all buffered and incoming records
- in_valid  in  1  upstream record valid
- in_ready  out  1  stage can accept a record this cycle
- in_kind  in  2  control-transfer kind: 0 BRANCH, 1 JAL, 2 JALR, 3 NONE
- in_funct3  in  3  branch condition code
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_rs1  in  XLEN  rs1 value (JALR base)
- cmp_eq  in  1  rs1 == rs2
- cmp_lt  in  1  signed rs1 < rs2
- cmp_ltu  in  1  unsigned rs1 < rs2
- pred_taken  in  1  front-end prediction
- pred_target  in  XLEN  predicted target
- out_valid  out  1  result record valid
- out_ready  in  1  downstream accepts record
- out_taken  out  1  control transfer taken
- out_target  out  XLEN  resolved target
- out_link  out  XLEN  pc + 4
- out_mispredict  out  1  resolution disagrees with prediction
- out_illegal  out  1  reserved funct3 on BRANCH
- out_misalign  out  1  taken target not 4-byte aligned (see Configuration)

## Operation
- Condition (BRANCH): 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 → taken=0, illegal=1.
- JAL/JALR: taken=1 unconditionally, funct3 ignored. NONE: taken=0, mispredict=pred_taken.
- Target: BRANCH/JAL = pc + imm; JALR = (rs1 + imm) with bit 0 cleared. All sums modulo 2^XLEN (0xFFFF_FFFC + 8 → 0x0000_0004).
- Link = pc + 4 modulo 2^XLEN for every kind.
- Mispredict = (taken != pred_taken) | (taken & target != pred_target). Illegal records: mispredict = pred_taken.
- Skid buffer states: EMPTY, ONE, TWO. in_ready = (state != TWO). Accept when in_valid & in_ready; emit when out_valid & out_ready.
- Transitions: EMPTY +accept → ONE; ONE +accept −emit → TWO; ONE −accept +emit → EMPTY; ONE accept&emit → ONE; TWO +emit → ONE (no accept possible).
- Output is always the oldest record; FIFO order preserved.
- flush: next state EMPTY, any same-cycle accept discarded, same-cycle emit still counts as delivered.

## Timing
- Reset: state EMPTY, out_valid=0, in_ready=1, all out_* data 0.
- Latency: record accepted at edge N is presented with out_valid=1 after edge N (one cycle) when buffer was EMPTY.
- Throughput: one record/cycle with out_ready held high.
- out_* stable while out_valid & !out_ready.
- in_ready depends only on registered state (no combinational path from out_ready).
- Reset asserted mid-stream: buffer cleared immediately, no records emitted after release until new accept.

## Configuration
- BRANCH_MISALIGN_TRAP_EN defined: out_misalign = taken & (target[1:0] != 0); misaligned record still emitted, out_mispredict unchanged.
- Undefined: out_misalign tied 0, alignment logic removed.

## Structure
- Package branch_pkg: cf_kind_e enum (BRANCH/JAL/JALR/NONE), funct3 localparams (BEQ…BGEU), br_result_t packed struct (taken, target, link, mispredict, illegal, misalign).
- Sub-module branch_skid_buf: generic two-entry valid/ready buffer parameterised on payload width, carrying br_result_t; resolution logic combinational in front of it.

## Test plan
- BRANCH funct3=100, cmp_lt=1, pc=0x100, imm=0x20, pred_taken=0 → taken=1, target=0x120, link=0x104, mispredict=1.
- JALR rs1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 → target=0x1006, mispredict=0; with macro defined out_misalign=1.
- BRANCH funct3=010, pred_taken=1 → taken=0, illegal=1, mispredict=1.
- pc=0xFFFF_FFFC, JAL imm=8 → target=0x0000_0004, link=0x0000_0000.
- Back-to-back accepts, out_ready=0 two cycles → in_ready drops after second accept; release out_ready → records emerge in order, one per cycle.
- State TWO, flush with in_valid=1 → out_valid=0 next cycle, in_ready=1, flushed-cycle input never emitted.
